// File: rtl/nx_ram_fifo_pkg.sv
// Shared sizing helpers for the RAM-backed FIFO controller.
package nx_ram_fifo_pkg;

  // Width of the occupancy count: it must hold up to DEPTH + RAM_LAT + 1 words.
  function automatic int unsigned nx_ram_fifo_lvl_w(input int unsigned depth, input int unsigned lat);
    return $clog2(depth + lat + 2);
  endfunction

  // The staging buffer needs one entry per in-flight read plus one for the head word.
  function automatic int unsigned nx_ram_fifo_stg_n(input int unsigned lat);
    return lat + 1;
  endfunction

endpackage

// File: rtl/nx_ram_fifo_stage.sv
// Small flop FIFO that absorbs RAM read returns and presents the head word.
module nx_ram_fifo_stage #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned ENTRIES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 din,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 dout,
  output logic [$clog2(ENTRIES+1)-1:0]     cnt
);

  localparam int unsigned PW = $clog2(ENTRIES);
  localparam int unsigned CW = $clog2(ENTRIES + 1);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    rd_idx;

  // ENTRIES need not be a power of two, so indices wrap explicitly.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dout = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_idx <= nxt(wr_idx);
      if (pop)  rd_idx <= nxt(rd_idx);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/nx_ram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 1R1W RAM with fixed read latency.
module nx_ram_fifo_ctrl
  import nx_ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned RAM_LAT      = 1,
  parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        clr,
  input  logic                                        wr_valid,
  output logic                                        wr_ready,
  input  logic [WIDTH-1:0]                            wr_data,
  output logic                                        rd_valid,
  input  logic                                        rd_ready,
  output logic [WIDTH-1:0]                            rd_data,
  output logic [nx_ram_fifo_lvl_w(DEPTH,RAM_LAT)-1:0] level,
  output logic                                        afull,
  output logic                                        ram_web,
  output logic [$clog2(DEPTH)-1:0]                    ram_wa,
  output logic [WIDTH-1:0]                            ram_din,
  output logic [WIDTH-1:0]                            ram_bwe,
  output logic                                        ram_reb,
  output logic [$clog2(DEPTH)-1:0]                    ram_ra,
  input  logic [WIDTH-1:0]                            ram_dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = nx_ram_fifo_lvl_w(DEPTH, RAM_LAT);
  localparam int unsigned S  = nx_ram_fifo_stg_n(RAM_LAT);
  localparam int unsigned CW = $clog2(S + 1);

  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [LW-1:0]      ram_cnt;
  logic [LW-1:0]      inflight;
  logic [LW-1:0]      stg_cnt_w;
  logic [LW-1:0]      level_nxt;
  logic [CW-1:0]      stg_cnt;
  logic [RAM_LAT-1:0] inflight_sr;
  logic               push;
  logic               pop;
  logic               issue;
  logic               stg_push;

  assign wr_ready  = (ram_cnt != LW'(DEPTH)) && !clr;
  assign push      = wr_valid && wr_ready;
  assign rd_valid  = (stg_cnt != '0);
  assign pop       = rd_valid && rd_ready && !clr;
  assign stg_cnt_w = LW'(stg_cnt);

  // A pop this cycle frees a staging slot in time for a read issued now.
  assign issue = !clr && (ram_cnt != '0) && ((stg_cnt_w + inflight) < (LW'(S) + LW'(pop)));

  // Returns landing during or after a flush see a cleared valid bit and are dropped.
  assign stg_push = inflight_sr[RAM_LAT-1] && !clr;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RAM_LAT; i++) begin
      inflight = inflight + LW'(inflight_sr[i]);
    end
  end

  assign level     = ram_cnt + inflight + stg_cnt_w;
  assign level_nxt = clr ? '0 : (level + LW'(push) - LW'(pop));

  assign ram_web = !push;
  assign ram_wa  = wptr;
  assign ram_din = wr_data;
  assign ram_bwe = '1;
  assign ram_reb = !issue;
  assign ram_ra  = rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      inflight_sr <= '0;
      afull       <= 1'b0;
    end else begin
      afull <= (level_nxt >= LW'(AFULL_THRESH));
      if (clr) begin
        wptr        <= '0;
        rptr        <= '0;
        ram_cnt     <= '0;
        inflight_sr <= '0;
      end else begin
        if (push)  wptr <= wptr + AW'(1);
        if (issue) rptr <= rptr + AW'(1);
        ram_cnt        <= ram_cnt + LW'(push) - LW'(issue);
        inflight_sr[0] <= issue;
        for (int unsigned i = 1; i < RAM_LAT; i++) begin
          inflight_sr[i] <= inflight_sr[i-1];
        end
      end
    end
  end

  nx_ram_fifo_stage #(
    .WIDTH   (WIDTH),
    .ENTRIES (S)
  ) u_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (stg_push),
    .din   (ram_dout),
    .pop   (pop),
    .dout  (rd_data),
    .cnt   (stg_cnt)
  );

endmodule

// File: tb/tb_nx_ram_fifo_ctrl.sv
// Directed bench for nx_ram_fifo_ctrl with a behavioural 2-cycle-latency RAM.
module tb_nx_ram_fifo_ctrl;
  import nx_ram_fifo_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 16;
  localparam int unsigned L  = 2;
  localparam int unsigned LW = nx_ram_fifo_lvl_w(D, L);

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [LW-1:0] level;
  logic          afull;
  logic          ram_web;
  logic [3:0]    ram_wa;
  logic [W-1:0]  ram_din;
  logic [W-1:0]  ram_bwe;
  logic          ram_reb;
  logic [3:0]    ram_ra;
  logic [W-1:0]  ram_dout;

  nx_ram_fifo_ctrl #(
    .WIDTH        (W),
    .DEPTH        (D),
    .RAM_LAT      (L),
    .AFULL_THRESH (12)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .afull    (afull),
    .ram_web  (ram_web),
    .ram_wa   (ram_wa),
    .ram_din  (ram_din),
    .ram_bwe  (ram_bwe),
    .ram_reb  (ram_reb),
    .ram_ra   (ram_ra),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read address sampled with reb low, data valid two cycles later.
  logic [W-1:0] mem [D];
  logic [W-1:0] rp1;
  always @(posedge clk) begin
    if (!ram_web) mem[ram_wa] <= ram_din;
    if (!ram_reb) rp1 <= mem[ram_ra];
    ram_dout <= rp1;
  end

  int           n_vec;
  int           n_err;
  int           lvl_m;
  int           ramc_m;
  int           pops;
  int           acc;
  int           sent;
  logic [3:0]   wptr_m;
  logic [3:0]   rptr_m;
  logic         afull_m;
  logic         last_push;
  logic [W-1:0] q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    lvl_m   = 0;
    ramc_m  = 0;
    wptr_m  = '0;
    rptr_m  = '0;
    afull_m = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cyc(input logic wv, input logic [W-1:0] wd, input logic rr, input logic cl);
    logic exp_wr;
    logic p;
    logic iss;
    logic pp;
    int   down;
    @(posedge clk);
    #1;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    clr      = cl;
    #1;
    exp_wr = (ramc_m != D) && !cl;
    chk("wr_ready", wr_ready, exp_wr);
    chk("level", level, lvl_m);
    chk("afull", afull, afull_m);
    p = wv && exp_wr;
    chk("ram_web", ram_web, !p);
    if (p) begin
      chk("ram_wa", ram_wa, wptr_m);
      chk("ram_din", ram_din, wd);
    end
    if (lvl_m == 0) chk("rd_valid_empty", rd_valid, 0);
    iss  = !ram_reb;
    pp   = rd_valid && rr && !cl;
    down = lvl_m - ramc_m;
    if (cl) begin
      chk("reb_clr", ram_reb, 1);
    end else if (iss) begin
      chk("issue_avail", ramc_m != 0, 1);
      chk("credit", (down - int'(pp)) < 3, 1);
      chk("ram_ra", ram_ra, rptr_m);
    end
    if (pp) begin
      if (q.size() == 0) chk("pop_empty", rd_valid, 0);
      else begin
        chk("rd_data", rd_data, q.pop_front());
        pops++;
      end
    end
    last_push = p;
    if (cl) reset_model();
    else begin
      if (p) begin
        q.push_back(wd);
        wptr_m = wptr_m + 4'd1;
        ramc_m++;
      end
      if (iss) begin
        ramc_m--;
        rptr_m = rptr_m + 4'd1;
      end
      lvl_m   = lvl_m + int'(p) - int'(pp);
      afull_m = (lvl_m >= 12);
    end
  endtask

  task automatic drain(input string tag);
    int expect_pops;
    expect_pops = lvl_m;
    pops = 0;
    for (int k = 0; k < 200 && lvl_m != 0; k++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk(tag, pops, expect_pops);
  endtask

  initial begin
    n_vec = 0; n_err = 0; pops = 0; last_push = 1'b0;
    rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    reset_model();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", afull, 0);
    chk("rst_web", ram_web, 1);
    chk("rst_reb", ram_reb, 1);
    chk("rst_wa", ram_wa, 0);
    chk("rst_ra", ram_ra, 0);
    chk("bwe", ram_bwe, 16'hFFFF);
    rst_n = 1'b1;
    #1;
    chk("rst_wr_ready", wr_ready, 1);

    // Single push: write c0, read issue c1, head valid c4, empty c5.
    cyc(1'b1, 16'h00A5, 1'b1, 1'b0); chk("sp_reb_c0", ram_reb, 1);
    cyc(1'b0, '0, 1'b1, 1'b0);       chk("sp_reb_c1", ram_reb, 0); chk("sp_rv_c1", rd_valid, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);       chk("sp_rv_c2", rd_valid, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);       chk("sp_rv_c3", rd_valid, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);       chk("sp_rv_c4", rd_valid, 1); chk("sp_data_c4", rd_data, 16'h00A5);
    cyc(1'b0, '0, 1'b1, 1'b0);       chk("sp_lvl_c5", level, 0); chk("sp_rv_c5", rd_valid, 0);

    // Streaming: no bubbles after the first word, level steady at 4.
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, W'(16'h0100 + k), 1'b1, 1'b0);
      if (k >= 4) begin
        chk("st_rv", rd_valid, 1);
        chk("st_lvl", level, 4);
      end
    end
    drain("st_drain");

    // Fill with the output stalled: 16 in RAM plus 3 downstream.
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, W'(16'h0200 + k), 1'b0, 1'b0);
      acc += int'(wr_ready);
    end
    chk("fill_acc", acc, 19);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_afull", afull, 1);
    chk("fill_level", level, 19);
    drain("fill_drain");

    // Random backpressure including long stalls.
    sent = 0;
    for (int k = 0; k < 8000 && sent < 1000; k++) begin
      cyc(($urandom_range(0, 3) != 0), W'($urandom),
          ((k % 97) >= 20) && ($urandom_range(0, 7) < 5), 1'b0);
      if (last_push) sent++;
    end
    chk("bp_sent", sent, 1000);
    drain("bp_drain");

    // Flush with 2 reads in flight and 5 words in the RAM.
    for (int k = 0; k < 8; k++) cyc(1'b1, W'(16'h0300 + k), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fl_level_pre", level, 8);
    cyc(1'b1, 16'h0310, 1'b1, 1'b0);
    cyc(1'b1, 16'h0311, 1'b1, 1'b0);
    chk("fl_level_clr", level, 8);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 16'h0077, 1'b1, 1'b0);
    chk("fl_rv_after", rd_valid, 0);
    drain("fl_drain");

    // Asynchronous reset in the middle of a stream.
    for (int k = 0; k < 10; k++) cyc(1'b1, W'(16'h0400 + k), 1'b1, 1'b0);
    rst_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("mr_rd_valid", rd_valid, 0);
    chk("mr_level", level, 0);
    chk("mr_afull", afull, 0);
    chk("mr_web", ram_web, 1);
    chk("mr_reb", ram_reb, 1);
    chk("mr_wa", ram_wa, 0);
    chk("mr_ra", ram_ra, 0);
    reset_model();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) cyc(1'b1, W'(16'h0500 + k), 1'b1, 1'b0);
    drain("mr_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
